jtframe_68kbusarb: RTL

//  Arbitrates the 68000 bus between the CPU and N external masters (DMA, sprite copier, blitter).

---
 rtl/jtframe_68kbusarb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/jtframe_68kbusarb.sv
// jtframe_68kbusarb
// Hands the 68000 bus to one of N external masters (DMA, sprite copier,
// blitter) using the CPU BRn/BGn/BGACKn handshake. After every release the
// CPU keeps the bus for at least MINCPU cpu_cen pulses, and a master that
// holds the bus too long is forced off.
//
// Ports
//   clk      system clock
//   rst      asynchronous, active-high reset
//   cpu_cen  CPU clock enable; the FSM only moves when this is high
//   BGn      bus grant from the CPU (active low)
//   ASn      CPU address strobe (active low)
//   BRn      bus request to the CPU (active low, registered)
//   BGACKn   bus grant acknowledge to the CPU (active low, registered)
//   req      per-master request level, held until the master is done
//   done     per-master release strobe, one clk wide
//   gnt      one-hot grant, at most one bit set
//   timeout  one clk pulse when a master is forcibly released
module jtframe_68kbusarb #(
  parameter int N       = 2,
  parameter int MINCPU  = 4,
  parameter int MAXHOLD = 255,
  parameter int HW      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_cen,
  input  logic         BGn,
  input  logic         ASn,
  output logic         BRn,
  output logic         BGACKn,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] gnt,
  output logic         timeout
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] OWN  = 2'd2;
  localparam logic [1:0] REL  = 2'd3;

  localparam logic [HW-1:0] HOLD_LIM  = (MAXHOLD == 0) ? '0 : HW'(MAXHOLD - 1);
  localparam logic [HW-1:0] GUARD_INI = HW'(MINCPU);

  logic [1:0]    state;
  logic [HW-1:0] guard;
  logic [HW-1:0] hold;
  logic [IW-1:0] last;
  logic [IW-1:0] cur;
  logic          done_seen;
  logic          done_now;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_oh;
  logic          found;

  // Round-robin pick: scan starting one past the last owner, wrapping round.
  always_comb begin
    win_idx = last;
    found   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(int'(last) + i) % N]) begin
        found   = 1'b1;
        win_idx = IW'((int'(last) + i) % N);
      end
    end
    win_oh = N'(1) << win_idx;
  end

  // done is only one clk wide, so a strobe that lands between enables is
  // remembered until the next cpu_cen.
  assign done_now = done_seen | (|(done & gnt));

  // Bus handshake FSM. gnt drops on the OWN->REL edge and BGACKn rises one
  // enable later, so the master is already off the bus when the CPU gets it
  // back. timeout is the only output that clears on a plain clk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      BRn       <= 1'b1;
      BGACKn    <= 1'b1;
      gnt       <= '0;
      timeout   <= 1'b0;
      guard     <= '0;
      hold      <= '0;
      last      <= '0;
      cur       <= '0;
      done_seen <= 1'b0;
    end else begin
      timeout   <= 1'b0;
      done_seen <= (state == OWN && !cpu_cen) ? done_now : 1'b0;
      if (cpu_cen) begin
        case (state)
          IDLE: begin
            if (|req && guard == '0) begin
              state <= REQ;
              BRn   <= 1'b0;
            end else if (guard != '0) begin
              guard <= guard - 1'b1;
            end
          end
          REQ: begin
            if (req == '0) begin
              state <= IDLE;
              BRn   <= 1'b1;
            end else if (!BGn && ASn && BGACKn) begin
              state  <= OWN;
              BGACKn <= 1'b0;
              BRn    <= 1'b1;
              gnt    <= win_oh;
              cur    <= win_idx;
              hold   <= '0;
            end
          end
          OWN: begin
            if (hold != '1) hold <= hold + 1'b1;
            // A normal release wins over a timeout on the same enable.
            if (done_now || !req[cur]) begin
              state <= REL;
              gnt   <= '0;
            end else if (MAXHOLD != 0 && hold == HOLD_LIM) begin
              state   <= REL;
              gnt     <= '0;
              timeout <= 1'b1;
            end
          end
          default: begin
            BGACKn <= 1'b1;
            last   <= cur;
            guard  <= GUARD_INI;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
